// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: byte-wide bus window at BASE_ADDR, transmit FIFO,
// programmable baud divider and a level interrupt when everything has drained.
module mmio_uart_tx #(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter logic [15:0] CLK_DIV    = 16'd434,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] address_i,
  input  logic [7:0]  data_i,
  input  logic        we_i,
  output logic [7:0]  data_o,
  output logic        sel_o,
  output logic        tx_o,
  output logic        irq_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIVLO  = 2'd2;
  localparam logic [1:0] OFF_DIVHI  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   div_q, div_d;
  logic [15:0]   bdiv_q, bdiv_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          irq_q, irq_d;
  logic          sel_q, sel_d;
  logic [7:0]    rdata_q, rdata_d;

  logic          hit_s, wr_s, rd_s;
  logic [1:0]    off_s;
  logic          full_s, empty_s;
  logic          push_req_s, push_s, pop_s, ovf_set_s;
  logic [15:0]   eff_div_s;
  logic [7:0]    status_s;

  function automatic logic [3:0] sat_count(input logic [CW-1:0] c);
    logic [31:0] w;
    w = 32'(c);
    if (w > 32'd15) begin
      return 4'hF;
    end else begin
      return w[3:0];
    end
  endfunction

  assign hit_s      = (address_i[15:2] == BASE_ADDR[15:2]);
  assign off_s      = address_i[1:0];
  assign wr_s       = we_i & hit_s;
  assign rd_s       = ~we_i & hit_s;
  assign full_s     = (count_q == DEPTH_C);
  assign empty_s    = (count_q == {CW{1'b0}});
  assign push_req_s = wr_s & (off_s == OFF_TXDATA);
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign push_s     = push_req_s & (~full_s | pop_s);
  assign ovf_set_s  = push_req_s & full_s & ~pop_s;
  assign eff_div_s  = (div_q < 16'd2) ? 16'd2 : div_q;
  assign status_s   = {sat_count(count_q), ovf_q, (state_q != ST_IDLE), empty_s, full_s};

  // Transmit FSM next-state, bit timing and serial line value.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    bdiv_d  = bdiv_q;
    pop_s   = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_d = mem_q[rptr_q];
          bdiv_d  = eff_div_s;
          cnt_d   = eff_div_s - 16'd1;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_q == 16'd0) begin
          state_d = ST_DATA;
          cnt_d   = bdiv_q - 16'd1;
          idx_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = bdiv_q - 16'd1;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == 16'd0) begin
          if (!empty_s) begin
            pop_s   = 1'b1;
            shift_d = mem_q[rptr_q];
            bdiv_d  = eff_div_s;
            cnt_d   = eff_div_s - 16'd1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // FIFO bookkeeping, register writes, read-data mux and interrupt level.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    div_d   = div_q;
    rdata_d = 8'h00;
    sel_d   = rd_s;
    if (push_s) begin
      wptr_d = wptr_q + PW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + PW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (wr_s && (off_s == OFF_STATUS) && data_i[3]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (wr_s && (off_s == OFF_DIVLO)) begin
      div_d = {div_q[15:8], data_i};
    end else if (wr_s && (off_s == OFF_DIVHI)) begin
      div_d = {data_i, div_q[7:0]};
    end else begin
      div_d = div_q;
    end
    if (rd_s) begin
      case (off_s)
        OFF_STATUS: rdata_d = status_s;
        OFF_DIVLO:  rdata_d = div_q[7:0];
        OFF_DIVHI:  rdata_d = div_q[15:8];
        default:    rdata_d = 8'h00;
      endcase
    end else begin
      rdata_d = 8'h00;
    end
    irq_d = (count_d == {CW{1'b0}}) && (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      wptr_q  <= {PW{1'b0}};
      rptr_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      ovf_q   <= 1'b0;
      div_q   <= CLK_DIV;
      bdiv_q  <= CLK_DIV;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      irq_q   <= 1'b1;
      sel_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      div_q   <= div_d;
      bdiv_q  <= bdiv_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      irq_q   <= irq_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (push_s) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  assign data_o = rdata_q;
  assign sel_o  = sel_q;
  assign tx_o   = tx_q;
  assign irq_o  = irq_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: register vector table, hand-written frame/overflow/reset
// sequences, and randomized bus traffic checked every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_mmio_uart_tx;
  localparam logic [15:0] BASE    = 16'hFF00;
  localparam logic [15:0] RST_DIV = 16'd434;
  localparam int          DEPTH   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] address;
  logic [7:0]  wdata;
  logic        we;
  logic [7:0]  data_o;
  logic        sel_o, tx_o, irq_o;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLK_DIV(RST_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .address_i(address), .data_i(wdata), .we_i(we),
    .data_o(data_o), .sel_o(sel_o), .tx_o(tx_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: byte queue plus the currently transmitting frame as (byte, div, elapsed edges).
  logic [7:0]  mq[$];
  bit          m_ovf;
  logic [15:0] m_div;
  bit          m_act;
  int          m_el, m_fdiv;
  logic [7:0]  m_fbyte;
  logic [7:0]  m_data;
  bit          m_sel, m_tx, m_irq;

  function automatic void model_reset();
    mq.delete();
    m_ovf = 1'b0; m_div = RST_DIV; m_act = 1'b0; m_el = 0; m_fdiv = 2; m_fbyte = 8'h00;
    m_data = 8'h00; m_sel = 1'b0; m_tx = 1'b1; m_irq = 1'b1;
  endfunction

  function automatic void model_edge();
    int n, off;
    bit hit, popped;
    logic [7:0] st;
    logic [9:0] fr;
    n = mq.size();
    st[7:4] = (n > 15) ? 4'hF : 4'(n);
    st[3] = m_ovf; st[2] = m_act; st[1] = (n == 0); st[0] = (n == DEPTH);
    hit = (address >= BASE) && (address <= BASE + 16'd3);
    off = int'(address - BASE);
    m_sel  = hit && !we;
    m_data = 8'h00;
    if (m_sel) begin
      case (off)
        1: m_data = st;
        2: m_data = m_div[7:0];
        3: m_data = m_div[15:8];
        default: m_data = 8'h00;
      endcase
    end
    popped = 1'b0;
    if (m_act) begin
      m_el++;
      if (m_el == 10 * m_fdiv) m_act = 1'b0;
    end
    if (!m_act && n > 0) begin
      m_fbyte = mq.pop_front();
      m_fdiv  = (m_div < 16'd2) ? 2 : int'(m_div);
      m_el    = 0;
      m_act   = 1'b1;
      popped  = 1'b1;
    end
    if (hit && we) begin
      case (off)
        0: if (n == DEPTH && !popped) m_ovf = 1'b1; else mq.push_back(wdata);
        1: if (wdata[3]) m_ovf = 1'b0;
        2: m_div[7:0] = wdata;
        3: m_div[15:8] = wdata;
        default: ;
      endcase
    end
    fr    = {1'b1, m_fbyte, 1'b0};
    m_tx  = m_act ? fr[m_el / m_fdiv] : 1'b1;
    m_irq = (mq.size() == 0) && !m_act;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
    check("model_tx",   32'(tx_o),   32'(m_tx));
    check("model_irq",  32'(irq_o),  32'(m_irq));
    check("model_sel",  32'(sel_o),  32'(m_sel));
    check("model_data", 32'(data_o), 32'(m_data));
  endtask

  task automatic bus_idle();
    address = 16'h0000; wdata = 8'h00; we = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    address = a; wdata = d; we = 1'b1;
    step();
    bus_idle();
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [7:0] exp, input string name);
    address = a; we = 1'b0;
    step();
    check(name, 32'(data_o), 32'(exp));
    check({name, "_sel"}, 32'(sel_o), 32'd1);
    bus_idle();
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        we;
    logic [7:0]  exp_data;
    logic        exp_sel;
  } vec_t;

  vec_t        vecs[16];
  logic [9:0]  frame;
  logic [19:0] frames;
  int          bad;
  int          r;

  initial begin
    vecs[0]  = '{16'hFF01, 8'h00, 1'b0, 8'h02, 1'b1};
    vecs[1]  = '{16'hFF02, 8'h00, 1'b0, 8'hB2, 1'b1};
    vecs[2]  = '{16'hFF03, 8'h00, 1'b0, 8'h01, 1'b1};
    vecs[3]  = '{16'hFF00, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[4]  = '{16'hFEFF, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{16'hFF04, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[6]  = '{16'hFF02, 8'h04, 1'b1, 8'h00, 1'b0};
    vecs[7]  = '{16'hFF03, 8'h00, 1'b1, 8'h00, 1'b0};
    vecs[8]  = '{16'hFF02, 8'h00, 1'b0, 8'h04, 1'b1};
    vecs[9]  = '{16'hFF03, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[10] = '{16'h1234, 8'hAA, 1'b1, 8'h00, 1'b0};
    vecs[11] = '{16'hFEFF, 8'h55, 1'b1, 8'h00, 1'b0};
    vecs[12] = '{16'hFF04, 8'h77, 1'b1, 8'h00, 1'b0};
    vecs[13] = '{16'hFF01, 8'h08, 1'b1, 8'h00, 1'b0};
    vecs[14] = '{16'hFF01, 8'h00, 1'b0, 8'h02, 1'b1};
    vecs[15] = '{16'hFEFF, 8'h00, 1'b0, 8'h00, 1'b0};

    rst = 1'b1;
    bus_idle();
    model_reset();
    repeat (2) step();
    check("reset_tx",   32'(tx_o),   32'd1);
    check("reset_irq",  32'(irq_o),  32'd1);
    check("reset_sel",  32'(sel_o),  32'd0);
    check("reset_data", 32'(data_o), 32'd0);
    rst = 1'b0;

    // Register map and window decode; divider left at 4.
    for (int i = 0; i < 16; i++) begin
      address = vecs[i].addr; wdata = vecs[i].data; we = vecs[i].we;
      step();
      check($sformatf("vec%0d_data", i), 32'(data_o), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_sel", i),  32'(sel_o),  32'(vecs[i].exp_sel));
      check($sformatf("vec%0d_irq", i),  32'(irq_o),  32'd1);
    end
    bus_idle();

    // Single frame 8'h55 at divider 4.
    address = BASE; wdata = 8'h55; we = 1'b1;
    step();
    bus_idle();
    check("A_irq_after_E0", 32'(irq_o), 32'd0);
    check("A_tx_after_E0",  32'(tx_o),  32'd1);
    frame = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 40; i++) begin
      step();
      check($sformatf("A_bit_clk%0d", i), 32'(tx_o), 32'(frame[i / 4]));
    end
    step();
    check("A_irq_end", 32'(irq_o), 32'd1);
    check("A_tx_end",  32'(tx_o),  32'd1);

    // Back-to-back frames with no idle gap.
    address = BASE; wdata = 8'hA3; we = 1'b1;
    step();
    wdata = 8'h0F;
    step();
    bus_idle();
    frames = {1'b1, 8'h0F, 1'b0, 1'b1, 8'hA3, 1'b0};
    check("B_bit_clk0", 32'(tx_o), 32'(frames[0]));
    for (int i = 1; i < 80; i++) begin
      step();
      check($sformatf("B_bit_clk%0d", i), 32'(tx_o), 32'(frames[i / 4]));
    end
    step();
    check("B_irq_end", 32'(irq_o), 32'd1);

    // FIFO fill, overflow and OVF clear at divider 100; first byte is 0 for the reset check.
    bus_write(BASE + 16'd2, 8'd100);
    bus_write(BASE + 16'd3, 8'd0);
    address = BASE; we = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wdata = (i == 0) ? 8'h00 : 8'(8'h10 + i);
      step();
    end
    bus_idle();
    bus_read(BASE + 16'd1, 8'h85, "C_status_full");
    bus_write(BASE, 8'hEE);
    bus_read(BASE + 16'd1, 8'h8D, "C_status_ovf");
    bus_write(BASE + 16'd1, 8'h08);
    bus_read(BASE + 16'd1, 8'h85, "C_ovf_cleared");

    // Reset in the middle of the data bits.
    repeat (380) step();
    check("D_tx_low_before_reset", 32'(tx_o), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("D_tx_async_reset",  32'(tx_o),  32'd1);
    check("D_irq_async_reset", 32'(irq_o), 32'd1);
    model_reset();
    step();
    rst = 1'b0;
    bus_read(BASE + 16'd1, 8'h02, "D_status_after_reset");
    bad = 0;
    repeat (1200) begin
      step();
      if (tx_o !== 1'b1) bad++;
    end
    check("D_no_frame_after_reset", 32'(bad), 32'd0);

    // Randomized traffic against the model.
    bus_write(BASE + 16'd2, 8'd3);
    bus_write(BASE + 16'd3, 8'd0);
    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom_range(0, 99));
      address = 16'h0000; we = 1'b0; wdata = 8'($urandom_range(0, 255));
      if (r < 30) begin
        address = BASE; we = 1'b1;
      end else if (r < 36) begin
        address = BASE + 16'd1;
      end else if (r < 39) begin
        address = BASE + 16'd2; we = 1'b1; wdata = 8'($urandom_range(0, 5));
      end else if (r < 41) begin
        address = BASE + 16'd3; we = 1'b1; wdata = 8'h00;
      end else if (r < 44) begin
        address = BASE + 16'd1; we = 1'b1;
      end else if (r < 52) begin
        address = BASE + 16'($urandom_range(0, 3));
      end else if (r < 56) begin
        address = 16'($urandom_range(0, 32'hFEFF)); we = 1'b1;
      end else if (r < 58) begin
        address = BASE + 16'd4 + 16'($urandom_range(0, 3)); we = 1'($urandom_range(0, 1));
      end
      step();
    end
    bus_idle();
    repeat (600) step();
    check("E_irq_drained", 32'(irq_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
